// File: rtl/dmem_latency_model_if.sv
// -----------------------------------------------------------------------------
// dmem_latency_model_if
//
// Line-request bus between the data cache (master) and the main-memory
// model (slave).
//
// Handshake: the master raises enable_i together with addr_i, write_i and
// data_i. It holds enable_i high until it sees ack_o. The slave latches the
// request at the edge where it accepts it, and pulses ack_o for exactly one
// cycle when the request completes. data_o carries the read line only while
// ack_o is high and is zero otherwise.
//
// Signals:
//   addr_i   [31:0]        byte address; the line index is taken from bit 5 up
//   data_i   [LINE_W-1:0]  write line
//   enable_i               request valid, held until ack_o
//   write_i                1 = write, 0 = read
//   ack_o                  one-cycle completion pulse
//   data_o   [LINE_W-1:0]  read line, valid with ack_o
// -----------------------------------------------------------------------------
interface dmem_latency_model_if #(
  parameter int LINE_W = 256
);
  logic [31:0]       addr_i;
  logic [LINE_W-1:0] data_i;
  logic              enable_i;
  logic              write_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;

  modport master (
    output addr_i,
    output data_i,
    output enable_i,
    output write_i,
    input  ack_o,
    input  data_o
  );

  modport slave (
    input  addr_i,
    input  data_i,
    input  enable_i,
    input  write_i,
    output ack_o,
    output data_o
  );
endinterface

// File: rtl/dmem_latency_model.sv
// -----------------------------------------------------------------------------
// dmem_latency_model
//
// Cycle-accurate model of off-chip main memory behind the data cache. It
// services one whole-line read or write at a time with a fixed latency. The
// latency is counted by an 8-bit down-counter. The line array is called
// `memory`, so a bench can preload it and inspect it hierarchically. The
// array is never reset.
//
// Parameters:
//   DEPTH    number of lines (default 512)
//   LINE_W   line width in bits (default 256)
//   LATENCY  cycles from acceptance to the edge where ack_o is sampled, 1..255
//
// Ports:
//   clk_i        clock; all state changes on the rising edge
//   rst_i        asynchronous active-low reset
//   bus          dmem_latency_model_if.slave (addr/data/enable/write/ack/data_o)
//   err_o        sticky address error; present only with DMEM_ADDR_CHECK_EN
//   dbg_state_o  FSM state: 0 = IDLE, 1 = WAIT, 2 = ACK
//
// Optional feature macro: DMEM_ADDR_CHECK_EN
//   Defined: err_o is set when a request is accepted with a non line-aligned
//   address, or with address bits above the array range. It stays set until
//   reset. The request is still serviced with the wrapped index.
//   Undefined: no err_o port and no check logic.
// -----------------------------------------------------------------------------
module dmem_latency_model #(
  parameter int DEPTH   = 512,
  parameter int LINE_W  = 256,
  parameter int LATENCY = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  dmem_latency_model_if.slave   bus,
`ifdef DMEM_ADDR_CHECK_EN
  output logic                  err_o,
`endif
  output logic [1:0]            dbg_state_o
);

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [7:0]          r_count;
  logic [IDX_W-1:0]    r_idx;
  logic                r_write;
  logic [LINE_W-1:0]   r_wdata;
  logic [LINE_W-1:0]   r_rdata;

  logic [LINE_W-1:0]   memory [DEPTH];

  logic                w_accept;
  logic                w_enter_ack;
  logic                w_ack;
  logic [IDX_W-1:0]    w_req_idx;
  logic [IDX_W-1:0]    w_op_idx;
  logic                w_op_write;
  logic [LINE_W-1:0]   w_op_wdata;

  // Upper address bits beyond the array are dropped, so addresses wrap.
  assign w_req_idx = bus.addr_i[IDX_W+4:5];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // WAIT leaves when the counter is about to reach 0. ACK is therefore entered
  // LATENCY-1 edges after acceptance, and the cache samples ack_o high at
  // edge t0+LATENCY. Back-to-back requests are then LATENCY+1 edges apart.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.enable_i) begin
          w_next_state = (LATENCY == 1) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_count <= 8'd1) begin
          w_next_state = S_ACK;
        end
      end
      S_ACK:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_accept    = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      S_IDLE:  w_accept = bus.enable_i;
      S_ACK:   w_ack    = 1'b1;
      default: begin
        w_accept = 1'b0;
        w_ack    = 1'b0;
      end
    endcase
    w_enter_ack = (w_next_state == S_ACK) && (r_state != S_ACK);
  end

  // With LATENCY == 1 the ACK entry edge is also the acceptance edge. The
  // request fields are not latched yet at that edge, so they are taken
  // straight from the bus. Otherwise the latched copy is used.
  assign w_op_idx   = w_accept ? w_req_idx   : r_idx;
  assign w_op_write = w_accept ? bus.write_i : r_write;
  assign w_op_wdata = w_accept ? bus.data_i  : r_wdata;

  // ---------------------------------------------------------------------------
  // Request latch and latency counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count <= 8'd0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_count <= LAT_LOAD;
      r_idx   <= w_req_idx;
      r_write <= bus.write_i;
      r_wdata <= bus.data_i;
    end else if ((r_state == S_WAIT) && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Line array. It has no reset, so preloads survive a reset. A reset in the
  // middle of a request forces IDLE, so w_enter_ack cannot fire and a pending
  // write is dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (w_enter_ack && w_op_write) begin
      memory[w_op_idx] <= w_op_wdata;
    end
  end

  // Read data is registered on ACK entry and cleared on every other edge.
  // It is therefore nonzero only during the ack cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rdata <= '0;
    end else if (w_enter_ack && !w_op_write) begin
      r_rdata <= memory[w_op_idx];
    end else begin
      r_rdata <= '0;
    end
  end

  assign bus.ack_o   = w_ack;
  assign bus.data_o  = r_rdata;
  assign dbg_state_o = r_state;

`ifdef DMEM_ADDR_CHECK_EN
  // ---------------------------------------------------------------------------
  // Sticky address check, evaluated only at acceptance
  // ---------------------------------------------------------------------------
  logic r_err;
  logic w_addr_bad;

  assign w_addr_bad = (bus.addr_i[4:0] != 5'd0) ||
                      (bus.addr_i[31:IDX_W+5] != '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_err <= 1'b0;
    end else if (w_accept && w_addr_bad) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  // Offset and out-of-range address bits have no function without the check.
  logic w_addr_unused;
  assign w_addr_unused = ^{bus.addr_i[31:IDX_W+5], bus.addr_i[4:0]};
`endif

endmodule
